processor_display_scan: RTL and testbench

//  Downstream consumer of the Processor debug outputs (IR_Out, PC_Out, StateO, NextStateO, ALU_A/B/Out).

---
 rtl/processor_debug_pkg.sv | 37 +++
 rtl/processor_display_scan_hex7seg.sv | 11 +
 rtl/processor_display_scan.sv | 100 ++++++++++
 tb/tb_processor_display_scan.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/processor_debug_pkg.sv
// Shared page encodings and seven-segment glyph table for the processor debug display.
package processor_debug_pkg;

  typedef enum logic [1:0] {
    PAGE_PC_IR   = 2'd0,
    PAGE_STATE   = 2'd1,
    PAGE_ALU_AB  = 2'd2,
    PAGE_ALU_OUT = 2'd3
  } page_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; lower-case b and d keep them distinct from 8 and 0.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [31:0] page_word(
    input page_e       pg,
    input logic [7:0]  pc,
    input logic [7:0]  st,
    input logic [7:0]  nx,
    input logic [15:0] ir,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] o
  );
    case (pg)
      PAGE_PC_IR:  return {pc, st, ir};
      PAGE_STATE:  return {st, nx, o};
      PAGE_ALU_AB: return {a, b};
      default:     return {16'h0000, o};
    endcase
  endfunction

endpackage

// File: rtl/processor_display_scan_hex7seg.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex7seg
  import processor_debug_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/processor_display_scan.sv
// Scans a frame-latched 32-bit debug word across an 8-digit multiplexed seven-segment display.
module processor_display_scan
  import processor_debug_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int NUM_DIGITS   = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Page,
  input  logic        Freeze,
  input  logic [15:0] IR_In,
  input  logic [7:0]  PC_In,
  input  logic [7:0]  State_In,
  input  logic [7:0]  Next_In,
  input  logic [15:0] A_In,
  input  logic [15:0] B_In,
  input  logic [15:0] Out_In,
  output logic [7:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        Frame
);

  localparam int DIV_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_DP   = IDX_W'(4);

  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      snap_q, snap_d;
  page_e            page_q, page_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;

  logic       tc;
  logic       load;
  logic       blank;
  logic [3:0] nibble;
  logic [6:0] hex_seg;

  assign tc   = (div_q == DIV_LAST);
  assign load = tc && (idx_q == '0) && !Freeze;

  // Display path works from the current index so outputs trail the index by one cycle.
  assign nibble = snap_q[{idx_q, 2'b00} +: 4];
  assign blank  = (page_q == PAGE_ALU_OUT) && idx_q[IDX_W-1];

  hex7seg u_hex7seg (
    .nibble_i (nibble),
    .seg_o    (hex_seg)
  );

  always_comb begin
    div_d   = tc ? '0 : div_q + 1'b1;
    idx_d   = tc ? idx_q - 1'b1 : idx_q;
    snap_d  = snap_q;
    page_d  = page_q;
    frame_d = load;
    if (load) begin
      snap_d = page_word(page_e'(Page), PC_In, State_In, Next_In, IR_In, A_In, B_In, Out_In);
      page_d = page_e'(Page);
    end
    an_d  = blank ? 8'hFF : ~(8'b1 << idx_q);
    seg_d = blank ? SEG_BLANK : hex_seg;
    dp_d  = !((idx_q == IDX_DP) && (page_q != PAGE_ALU_OUT));
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div_q   <= '0;
      idx_q   <= IDX_TOP;
      snap_q  <= '0;
      page_q  <= PAGE_PC_IR;
      an_q    <= 8'hFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      page_q  <= page_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign An    = an_q;
  assign Seg   = seg_q;
  assign Dp    = dp_q;
  assign Frame = frame_q;

endmodule

// File: tb/tb_processor_display_scan.sv
// Bench for processor_display_scan: cycle-count reference model plus directed frame checks.
module tb_processor_display_scan;

  localparam int DC = 4;
  localparam int FR = 8 * DC;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  Page = 2'd0;
  logic        Freeze = 1'b0;
  logic [15:0] IR_In = '0, A_In = '0, B_In = '0, Out_In = '0;
  logic [7:0]  PC_In = '0, State_In = '0, Next_In = '0;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Dp, Frame;

  int checks = 0;
  int errors = 0;
  logic [6:0] seen_seg [8];

  processor_display_scan #(.DIGIT_CYCLES(DC), .NUM_DIGITS(8)) dut (
    .Clk(Clk), .Reset(Reset), .Page(Page), .Freeze(Freeze),
    .IR_In(IR_In), .PC_In(PC_In), .State_In(State_In), .Next_In(Next_In),
    .A_In(A_In), .B_In(B_In), .Out_In(Out_In),
    .An(An), .Seg(Seg), .Dp(Dp), .Frame(Frame)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [31:0] word_of(input logic [1:0] pg);
    case (pg)
      2'd0: return PC_In * 32'h0100_0000 + State_In * 32'h0001_0000 + IR_In;
      2'd1: return State_In * 32'h0100_0000 + Next_In * 32'h0001_0000 + Out_In;
      2'd2: return A_In * 32'h0001_0000 + B_In;
      default: return {16'h0000, Out_In};
    endcase
  endfunction

  // Digit lit after t scan cycles since reset release.
  function automatic int digit_of(input int t);
    return 7 - ((t / DC) % 8);
  endfunction

  function automatic logic [7:0] exp_an(input int t, input logic [1:0] pg);
    int d = digit_of(t);
    if (pg == 2'd3 && d >= 4) return 8'hFF;
    return ~(8'h01 << d);
  endfunction

  function automatic logic [6:0] exp_seg(input int t, input logic [1:0] pg, input logic [31:0] w);
    int d = digit_of(t);
    if (pg == 2'd3 && d >= 4) return 7'h7F;
    return glyph(4'((w >> (4 * d)) & 32'hF));
  endfunction

  function automatic logic exp_dp(input int t, input logic [1:0] pg);
    return !(digit_of(t) == 4 && pg != 2'd3);
  endfunction

  int          m_t = 0;
  logic [31:0] m_snap = '0;
  logic [1:0]  m_page = '0;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame;

  always @(posedge Clk) begin
    if (!Reset) begin
      m_t <= 0; m_snap <= '0; m_page <= '0;
      e_an <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1'b1; e_frame <= 1'b0;
    end else begin
      e_an  <= exp_an(m_t, m_page);
      e_seg <= exp_seg(m_t, m_page, m_snap);
      e_dp  <= exp_dp(m_t, m_page);
      if ((m_t + 1) % FR == 0 && !Freeze) begin
        m_snap <= word_of(Page); m_page <= Page; e_frame <= 1'b1;
      end else begin
        e_frame <= 1'b0;
      end
      m_t <= m_t + 1;
    end
  end

  always @(negedge Clk) begin
    checks++;
    if ({An, Seg, Dp, Frame} !== {e_an, e_seg, e_dp, e_frame}) begin
      errors++;
      if (errors < 20)
        $display("FAIL cycle t=%0d: An=%h Seg=%h Dp=%b Frame=%b, model An=%h Seg=%h Dp=%b Frame=%b",
                 m_t, An, Seg, Dp, Frame, e_an, e_seg, e_dp, e_frame);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_frame(input string nm);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (Frame !== 1'b1 && n < 3 * FR);
    check({nm, " frame pulse"}, 32'(Frame), 32'd1);
  endtask

  // Watches one full frame starting just after a frame boundary.
  task automatic check_frame(input string nm, input logic [31:0] exp, input bit blank_hi,
                             input int mod_at, input logic [15:0] mod_a, output int pulses);
    int bad = 0;
    pulses = 0;
    for (int i = 0; i < FR; i++) begin
      @(negedge Clk);
      if (i == mod_at) A_In = mod_a;
      if (Frame === 1'b1) pulses++;
      if ($countones(~An) != 1 && !(blank_hi && An == 8'hFF)) bad++;
      for (int d = 0; d < 8; d++) begin
        if (An[d] == 1'b0) begin
          seen_seg[d] = Seg;
          if (Seg !== glyph(exp[4*d +: 4])) bad++;
          if (blank_hi && d >= 4) bad++;
        end
      end
      if (blank_hi) begin
        if (Dp == 1'b0) bad++;
      end else if ((An[4] == 1'b0) != (Dp == 1'b0)) bad++;
    end
    check({nm, " frame content"}, bad, 0);
  endtask

  task automatic rand_inputs();
    IR_In = 16'($urandom); PC_In = 8'($urandom); State_In = 8'($urandom);
    Next_In = 8'($urandom); A_In = 16'($urandom); B_In = 16'($urandom);
    Out_In = 16'($urandom); Page = 2'($urandom);
  endtask

  initial begin
    int p, tot, n;
    repeat (3) @(negedge Clk);
    check("reset An", An, 8'hFF);
    check("reset Seg", Seg, 7'h7F);
    check("reset Dp", Dp, 1'b1);
    check("reset Frame", Frame, 1'b0);

    Page = 2'd0; PC_In = 8'h12; State_In = 8'h03; IR_In = 16'hABCD;
    Reset = 1'b1;
    @(negedge Clk);
    check("first An", An, 8'h7F);
    check("pre-load zero glyph", Seg, 7'h40);

    wait_frame("page0");
    check_frame("page0", 32'h1203ABCD, 1'b0, -1, 16'h0, p);
    check("page0 digit7", seen_seg[7], 7'h79);
    check("page0 digit3", seen_seg[3], 7'h08);
    check("page0 digit0", seen_seg[0], 7'h21);

    Page = 2'd2; A_In = 16'h00FF; B_In = 16'h1234;
    wait_frame("page2");
    check_frame("page2 no tear", 32'h00FF1234, 1'b0, 10, 16'hFFFF, p);
    check_frame("page2 next", 32'hFFFF1234, 1'b0, -1, 16'h0, p);

    Freeze = 1'b1;
    rand_inputs();
    Page = 2'd1;
    tot = 0;
    for (int f = 0; f < 3; f++) begin
      check_frame("frozen", 32'hFFFF1234, 1'b0, -1, 16'h0, p);
      tot += p;
    end
    check("frozen frame pulses", tot, 0);

    Freeze = 1'b0; Page = 2'd3; Out_In = 16'h0042;
    wait_frame("page3");
    check_frame("page3", 32'h00000042, 1'b1, -1, 16'h0, p);
    check("page3 digit1", seen_seg[1], 7'h19);
    check("page3 digit0", seen_seg[0], 7'h24);

    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (An !== 8'hF7 && n < 2 * FR);
    check("digit3 reached", An, 8'hF7);
    Reset = 1'b0;
    @(negedge Clk);
    check("mid reset An", An, 8'hFF);
    check("mid reset Seg", Seg, 7'h7F);
    check("mid reset Frame", Frame, 1'b0);
    Reset = 1'b1;
    @(negedge Clk);
    check("restart An", An, 8'h7F);
    check("restart zero", Seg, 7'h40);

    for (int c = 0; c < 20 * FR; c++) begin
      @(negedge Clk);
      if ($urandom_range(0, 7) == 0) rand_inputs();
      if ($urandom_range(0, 15) == 0) Freeze = ($urandom_range(0, 2) == 0);
      Reset = ($urandom_range(0, 299) != 0);
    end
    Reset = 1'b1;
    repeat (4) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
